// File: rtl/graphics_pkg.sv
// Shared colours, glyph count, BCD digit type and converter states for graphics_number.
package graphics_pkg;

    localparam logic [2:0] COL_BLACK  = 3'b000;
    localparam logic [2:0] COL_BLUE   = 3'b001;
    localparam logic [2:0] COL_GREEN  = 3'b010;
    localparam logic [2:0] COL_RED    = 3'b100;
    localparam logic [2:0] COL_YELLOW = 3'b110;
    localparam logic [2:0] COL_WHITE  = 3'b111;

    localparam int GLYPH_COUNT = 10;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_t;

    function automatic bcd_digit_t dabble_adj(input bcd_digit_t d);
        return (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter with saturation to all nines.
// state     | meaning
// ST_IDLE   | waiting for load; value latched on load
// ST_SHIFT  | one add-3/shift step per cycle, VALUE_W cycles
// ST_COMMIT | publish (possibly saturated) BCD result and pulse done
module bin2bcd_seq
    import graphics_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int VALUE_W = 14
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  load,
    input  logic [VALUE_W-1:0]    value,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  done
);
    localparam int BCD_W   = 4 * DIGITS;
    localparam int CNT_W   = $clog2(VALUE_W + 1);
    localparam int MAX_VAL = 10 ** DIGITS - 1;

    conv_state_t        state_q, state_d;
    logic [VALUE_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]   acc_q, acc_d;
    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic               done_q, done_d;

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        done_d  = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            adj[4*k +: 4] = dabble_adj(acc_q[4*k +: 4]);
        end
        case (state_q)
            ST_IDLE: begin
                // done_q still counts as busy, so a load in that cycle is dropped
                if (load && !done_q) begin
                    bin_d   = value;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(VALUE_W - 1);
                    sat_d   = 32'(value) > 32'(MAX_VAL);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                acc_d = BCD_W'({adj, bin_q[VALUE_W-1]});
                bin_d = bin_q << 1;
                if (cnt_q == '0) begin
                    state_d = ST_COMMIT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_COMMIT: begin
                bcd_d   = sat_q ? {DIGITS{4'd9}} : acc_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            acc_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE) || done_q;
    assign bcd  = bcd_q;
    assign done = done_q;

endmodule

// File: rtl/image.sv
// Digit-glyph ROM: glyphs 0-9 stacked vertically, seven-segment strokes, 1-cycle registered read.
module image
    import graphics_pkg::*;
#(
    parameter int WIDTH  = 21,
    parameter int HEIGHT = 23
) (
    input  logic       clk,
    input  logic [7:0] x_img,
    input  logic [7:0] y_img,
    output logic       pixel
);
    localparam int T     = 3;
    localparam int MID   = (HEIGHT - T) / 2;
    localparam int RIGHT = WIDTH - T;

    logic [3:0] glyph;
    logic [7:0] row;
    logic [6:0] seg;
    logic       top, midr, bot, left, right, upper, lower, inx;
    logic       pixel_d, pixel_q;

    always_comb begin
        glyph = 4'd0;
        row   = y_img;
        for (int g = 1; g < GLYPH_COUNT; g++) begin
            if (y_img >= 8'(g * HEIGHT)) begin
                glyph = 4'(g);
                row   = y_img - 8'(g * HEIGHT);
            end
        end
        // segment order {a,b,c,d,e,f,g}
        case (glyph)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1111011;
            default: seg = 7'b0000000;
        endcase
        inx   = x_img < 8'(WIDTH);
        left  = x_img < 8'(T);
        right = (x_img >= 8'(RIGHT)) && inx;
        top   = row < 8'(T);
        midr  = (row >= 8'(MID)) && (row < 8'(MID + T));
        bot   = (row >= 8'(HEIGHT - T)) && (row < 8'(HEIGHT));
        upper = row < 8'(MID + T);
        lower = (row >= 8'(MID)) && (row < 8'(HEIGHT));
        pixel_d = (seg[6] && top   && inx)
                | (seg[5] && right && upper)
                | (seg[4] && right && lower)
                | (seg[3] && bot   && inx)
                | (seg[2] && left  && lower)
                | (seg[1] && left  && upper)
                | (seg[0] && midr  && inx);
    end

    always_ff @(posedge clk) begin
        pixel_q <= pixel_d;
    end

    assign pixel = pixel_q;

endmodule

// File: rtl/graphics_number.sv
// Multi-digit decimal renderer: converter, atomic display register, 2-stage pixel pipeline.
// Optional leading-zero blanking via `GRAPHICS_NUMBER_LZB_EN.
module graphics_number
    import graphics_pkg::*;
#(
    parameter int         DIGITS       = 4,
    parameter int         VALUE_W      = 14,
    parameter int         WIDTH_DIGIT  = 21,
    parameter int         HEIGHT_DIGIT = 23,
    parameter int         SPACING      = 2,
    parameter logic [2:0] INK          = COL_YELLOW,
    parameter logic [2:0] BACKGROUND   = COL_BLACK,
    parameter logic [2:0] BG_NUMBER    = COL_BLACK
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [9:0]         x_px,
    input  logic [9:0]         y_px,
    input  logic [9:0]         x_pos,
    input  logic [9:0]         y_pos,
    input  logic [VALUE_W-1:0] value,
    input  logic               load,
    output logic               busy,
    output logic [2:0]         color_px
);
    localparam int PITCH = WIDTH_DIGIT + SPACING;
    localparam int BOX_W = DIGITS * WIDTH_DIGIT + (DIGITS - 1) * SPACING;
    localparam int BCD_W = 4 * DIGITS;

    logic [BCD_W-1:0] conv_bcd;
    logic             conv_done;
    logic [BCD_W-1:0] disp_q, disp_d;

    bin2bcd_seq #(
        .DIGITS  (DIGITS),
        .VALUE_W (VALUE_W)
    ) u_conv (
        .clk   (clk),
        .clr   (clr),
        .load  (load),
        .value (value),
        .busy  (busy),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

    always_comb begin
        disp_d = conv_done ? conv_bcd : disp_q;
    end

    logic [10:0]      x_end, y_end;
    logic             in_box, gap, blank;
    logic [9:0]       dx;
    logic [7:0]       col, x_img, y_img;
    bcd_digit_t       digit_val;
    logic [DIGITS-1:0] lead_zero;
    logic             zero_run;

    always_comb begin
        x_end  = {1'b0, x_pos} + 11'(BOX_W);
        y_end  = {1'b0, y_pos} + 11'(HEIGHT_DIGIT);
        in_box = (x_px >= x_pos) && ({1'b0, x_px} < x_end)
              && (y_px >= y_pos) && ({1'b0, y_px} < y_end);
        dx     = x_px - x_pos;

        zero_run  = 1'b1;
        lead_zero = '0;
`ifdef GRAPHICS_NUMBER_LZB_EN
        for (int k = 0; k < DIGITS; k++) begin
            zero_run     = zero_run && (disp_q[BCD_W-1-4*k -: 4] == 4'd0);
            lead_zero[k] = zero_run && (k != DIGITS - 1);
        end
`endif

        col       = dx[7:0];
        digit_val = disp_q[BCD_W-1 -: 4];
        blank     = lead_zero[0];
        // comparator chain picks the right-most digit slot whose start is <= dx
        for (int k = 1; k < DIGITS; k++) begin
            if (dx >= 10'(k * PITCH)) begin
                col       = 8'(dx - 10'(k * PITCH));
                digit_val = disp_q[BCD_W-1-4*k -: 4];
                blank     = lead_zero[k];
            end
        end
        gap   = col >= 8'(WIDTH_DIGIT);
        x_img = col;
        y_img = 8'(y_px - y_pos) + 8'({4'd0, digit_val} * 8'(HEIGHT_DIGIT));
    end

    logic rom_px;

    image #(
        .WIDTH  (WIDTH_DIGIT),
        .HEIGHT (HEIGHT_DIGIT)
    ) u_image (
        .clk   (clk),
        .x_img (x_img),
        .y_img (y_img),
        .pixel (rom_px)
    );

    logic       in_q, gap_q, blank_q;
    logic [2:0] color_q, color_d;

    always_comb begin
        if (!in_q) begin
            color_d = BACKGROUND;
        end else if (gap_q || blank_q || !rom_px) begin
            color_d = BG_NUMBER;
        end else begin
            color_d = INK;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            disp_q  <= '0;
            in_q    <= 1'b0;
            gap_q   <= 1'b0;
            blank_q <= 1'b0;
            color_q <= BACKGROUND;
        end else begin
            disp_q  <= disp_d;
            in_q    <= in_box;
            gap_q   <= gap;
            blank_q <= blank;
            color_q <= color_d;
        end
    end

    assign color_px = color_q;

endmodule

// File: tb/tb_graphics_number.sv
// Directed, table-driven bench for graphics_number (honours `GRAPHICS_NUMBER_LZB_EN).
module tb_graphics_number;

    localparam logic [2:0] C_INK = 3'b110;
    localparam logic [2:0] C_BKG = 3'b000;
    localparam logic [2:0] C_BGN = 3'b001;
    localparam int X0 = 100;
    localparam int Y0 = 50;
`ifdef GRAPHICS_NUMBER_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr;
    logic [9:0]  x_px, y_px, x_pos, y_pos;
    logic [13:0] value;
    logic        load;
    logic        busy;
    logic [2:0]  color_px;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         phase;
        int         dx;
        int         dy;
        logic [2:0] exp;
    } vec_t;

    vec_t vecs[$];

    graphics_number #(
        .DIGITS       (4),
        .VALUE_W      (14),
        .WIDTH_DIGIT  (21),
        .HEIGHT_DIGIT (23),
        .SPACING      (2),
        .INK          (C_INK),
        .BACKGROUND   (C_BKG),
        .BG_NUMBER    (C_BGN)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .x_px     (x_px),
        .y_px     (y_px),
        .x_pos    (x_pos),
        .y_pos    (y_pos),
        .value    (value),
        .load     (load),
        .busy     (busy),
        .color_px (color_px)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_px(input int dx, input int dy);
        x_px = 10'(X0 + dx);
        y_px = 10'(Y0 + dy);
    endtask

    // called and returns at #1 after a rising edge
    task automatic probe(input int dx, input int dy, output logic [2:0] c);
        set_px(dx, dy);
        @(posedge clk);
        @(posedge clk);
        #1 c = color_px;
    endtask

    task automatic run_phase(input int ph);
        logic [2:0] c;
        foreach (vecs[i]) begin
            if (vecs[i].phase == ph) begin
                probe(vecs[i].dx, vecs[i].dy, c);
                check3($sformatf("px ph%0d (%0d,%0d)", ph, vecs[i].dx, vecs[i].dy), c, vecs[i].exp);
            end
        end
    endtask

    task automatic wait_idle(output int busy_cycles);
        busy_cycles = 0;
        while (busy && busy_cycles < 40) begin
            busy_cycles++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input int v, output int busy_cycles);
        value = 14'(v);
        load  = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        wait_idle(busy_cycles);
    endtask

    initial begin
        int         bc;
        logic [2:0] c;

        // phase 0: 0000 (after reset)
        vecs.push_back('{0,  1,  1, LZB ? C_BGN : C_INK});
        vecs.push_back('{0, 10, 11, C_BGN});
        vecs.push_back('{0, 70,  5, C_INK});
        vecs.push_back('{0, -1,  0, C_BKG});
        // phase 1: 1234
        vecs.push_back('{1,  1,  1, C_BGN});
        vecs.push_back('{1, 19,  1, C_INK});
        vecs.push_back('{1, 21,  1, C_BGN});
        vecs.push_back('{1, 22, 11, C_BGN});
        vecs.push_back('{1, 33,  1, C_INK});
        vecs.push_back('{1, 24,  5, C_BGN});
        vecs.push_back('{1, 24, 15, C_INK});
        vecs.push_back('{1, 47, 15, C_BGN});
        vecs.push_back('{1, 56, 11, C_INK});
        vecs.push_back('{1, 56, 21, C_INK});
        vecs.push_back('{1, 70,  5, C_INK});
        vecs.push_back('{1, 79,  1, C_BGN});
        vecs.push_back('{1, 88, 20, C_INK});
        vecs.push_back('{1, 79, 21, C_BGN});
        vecs.push_back('{1, 89,  0, C_INK});
        vecs.push_back('{1, 90,  0, C_BKG});
        vecs.push_back('{1, -1,  1, C_BKG});
        vecs.push_back('{1,  0, 23, C_BKG});
        // phase 2: saturated 9999
        vecs.push_back('{2,  1, 15, C_BGN});
        vecs.push_back('{2,  1,  5, C_INK});
        vecs.push_back('{2, 10, 21, C_INK});
        vecs.push_back('{2, 70, 15, C_BGN});
        // phase 3: 0007
        vecs.push_back('{3, 79,  1, C_INK});
        vecs.push_back('{3, 70,  5, C_BGN});
        vecs.push_back('{3,  1,  5, LZB ? C_BGN : C_INK});
        // phase 4: 0042 with blanking
        vecs.push_back('{4,  1,  5, C_BGN});
        vecs.push_back('{4, 24,  5, C_BGN});
        vecs.push_back('{4, 47,  5, C_INK});
        vecs.push_back('{4, 79,  1, C_INK});
        // phase 5: 0 with blanking
        vecs.push_back('{5, 70,  5, C_INK});
        vecs.push_back('{5, 47,  5, C_BGN});
        vecs.push_back('{5,  1,  5, C_BGN});

        clr   = 1'b0;
        load  = 1'b0;
        value = '0;
        x_pos = 10'(X0);
        y_pos = 10'(Y0);
        set_px(1, 1);
        repeat (3) @(posedge clk);
        #1;
        check3("reset color", color_px, C_BKG);
        check_int("reset busy", int'(busy), 0);
        clr = 1'b1;
        run_phase(0);

        do_load(1234, bc);
        check_int("busy cycles 1234", bc, 16);
        run_phase(1);

        // back-to-back pixels: each colour must land exactly two edges later
        set_px(-1, 0);
        @(posedge clk);
        @(posedge clk);
        #1 set_px(19, 1);
        @(posedge clk);
        #1 check3("stream lat1", color_px, C_BKG);
        set_px(21, 1);
        @(posedge clk);
        #1 check3("stream A ink", color_px, C_INK);
        set_px(0, 23);
        @(posedge clk);
        #1 check3("stream B gap", color_px, C_BGN);
        @(posedge clk);
        #1 check3("stream C out", color_px, C_BKG);

        do_load(12345, bc);
        check_int("busy cycles 12345", bc, 16);
        run_phase(2);

        // second load while busy must be dropped
        value = 14'd7;
        load  = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        check_int("busy after load", int'(busy), 1);
        @(posedge clk);
        @(posedge clk);
        #1 value = 14'd55;
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        wait_idle(bc);
        check_int("busy cycles 7 (remaining)", bc, 13);
        repeat (3) @(posedge clk);
        #1 check_int("busy after drop", int'(busy), 0);
        run_phase(3);

        // reset in mid-conversion clears display and aborts the FSM
        value = 14'd1234;
        load  = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        repeat (5) @(posedge clk);
        #1 clr = 1'b0;
        @(posedge clk);
        #1 check_int("busy mid reset", int'(busy), 0);
        clr = 1'b1;
        repeat (20) @(posedge clk);
        #1 check_int("busy after abort", int'(busy), 0);
        run_phase(0);

`ifdef GRAPHICS_NUMBER_LZB_EN
        do_load(42, bc);
        check_int("busy cycles 42", bc, 16);
        run_phase(4);
        do_load(0, bc);
        check_int("busy cycles 0", bc, 16);
        run_phase(5);
`endif

        probe(-1, -1, c);
        check3("final outside", c, C_BKG);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
